// File: rtl/char_pkg.sv
`default_nettype none
// ============================================================================
// Module   : char_pkg
// Brief    : Shared types and constants for the characterization sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package char_pkg;

    localparam int CHAR_NBSLOPES    = 7;
    localparam int CHAR_NBCAPA      = 7;
    localparam int CHAR_TICK_CYCLES = 16;

    localparam int IDX_W = 3;
    localparam int REC_W = 6;

    localparam logic [3:0] C_ST_IDLE   = 4'd0;
    localparam logic [3:0] C_ST_SLOPE  = 4'd1;
    localparam logic [3:0] C_ST_CAP    = 4'd2;
    localparam logic [3:0] C_ST_SETTLE = 4'd3;
    localparam logic [3:0] C_ST_P1     = 4'd4;
    localparam logic [3:0] C_ST_P2     = 4'd5;
    localparam logic [3:0] C_ST_P3     = 4'd6;
    localparam logic [3:0] C_ST_P4     = 4'd7;
    localparam logic [3:0] C_ST_CHECK  = 4'd8;
    localparam logic [3:0] C_ST_REC    = 4'd9;
    localparam logic [3:0] C_ST_P5     = 4'd10;
    localparam logic [3:0] C_ST_P6     = 4'd11;

    typedef enum logic [3:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_SLOPE  = C_ST_SLOPE,
        ST_CAP    = C_ST_CAP,
        ST_SETTLE = C_ST_SETTLE,
        ST_P1     = C_ST_P1,
        ST_P2     = C_ST_P2,
        ST_P3     = C_ST_P3,
        ST_P4     = C_ST_P4,
        ST_CHECK  = C_ST_CHECK,
        ST_REC    = C_ST_REC,
        ST_P5     = C_ST_P5,
        ST_P6     = C_ST_P6
    } char_state_t;

    // Flat grid index: slope-major, load-minor.
    function automatic logic [REC_W-1:0] point_index(
        input logic [IDX_W-1:0] slope,
        input logic [IDX_W-1:0] capa,
        input int               nbcapa
    );
        return REC_W'(slope) * REC_W'(nbcapa) + REC_W'(capa);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchronizer bringing the asynchronous DUT output into clk.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/char_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : char_sweep_sequencer
// Brief    : Walks the slope x load grid, drives the flop-under-test capture
//            pattern and emits one pass/fail record per point. Defining
//            CHAR_ABORT_ON_MISMATCH_EN ends the sweep at the first failing record.
// Revision : 1.0 - initial release
// ============================================================================
module char_sweep_sequencer
    import char_pkg::*;
#(
    parameter int NBSLOPES    = CHAR_NBSLOPES,
    parameter int NBCAPA      = CHAR_NBCAPA,
    parameter int TICK_CYCLES = CHAR_TICK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] slope_idx,
    output logic [IDX_W-1:0] capa_idx,
    output logic             ff_clk,
    output logic             ff_din,
    input  logic             ff_dout,
    output logic             meas_strobe,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_index,
    output logic             rec_pass,
    output logic [REC_W-1:0] fail_count
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] C_TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  C_SLOPE_LAST = IDX_W'(NBSLOPES - 1);
    localparam logic [IDX_W-1:0]  C_CAPA_LAST  = IDX_W'(NBCAPA - 1);

    char_state_t       r_state;
    logic [TICK_W-1:0] r_tick;
    logic [IDX_W-1:0]  r_slope;
    logic [IDX_W-1:0]  r_capa;
    logic              r_ff_clk;
    logic              r_ff_din;
    logic              r_ref_q;
    logic              r_busy;
    logic              r_done;
    logic              r_strobe;
    logic              r_valid;
    logic [REC_W-1:0]  r_index;
    logic              r_pass;
    logic [REC_W-1:0]  r_fail;

    char_state_t       w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [IDX_W-1:0]  w_slope_nxt;
    logic [IDX_W-1:0]  w_capa_nxt;
    logic              w_ff_clk_nxt;
    logic              w_ff_din_nxt;
    logic              w_done_nxt;
    logic              w_dout_sync;
    logic              w_tick_end;
    logic              w_accept;
    logic              w_start_acc;
    logic              w_enter_check;
    logic              w_match;
    logic [REC_W-1:0]  w_point;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (ff_dout),
        .q   (w_dout_sync)
    );

    assign w_tick_end    = (r_tick == C_TICK_LAST);
    assign w_accept      = r_valid & rec_ready;
    assign w_start_acc   = (r_state == ST_IDLE) & start;
    assign w_enter_check = (r_state == ST_P4) & w_tick_end;
    assign w_match       = (w_dout_sync == r_ref_q);
    assign w_point       = point_index(r_slope, r_capa, NBCAPA);

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick + 1'b1;
        w_slope_nxt  = r_slope;
        w_capa_nxt   = r_capa;
        w_ff_clk_nxt = r_ff_clk;
        w_ff_din_nxt = r_ff_din;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tick_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_SLOPE;
                    w_slope_nxt = '0;
                    w_capa_nxt  = '0;
                end
            end
            ST_CHECK, ST_REC: begin
                // Pins stay parked at clk=1/din=1 for as long as the logger stalls.
                w_tick_nxt = '0;
                if (r_state == ST_CHECK) begin
                    w_state_nxt = ST_REC;
                end
`ifdef CHAR_ABORT_ON_MISMATCH_EN
                if (w_accept && !r_pass) begin
                    w_state_nxt  = ST_IDLE;
                    w_ff_clk_nxt = 1'b0;
                    w_ff_din_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_P5;
                end
`else
                if (w_accept) begin
                    w_state_nxt = ST_P5;
                end
`endif
            end
            default: begin
                if (w_tick_end) begin
                    w_tick_nxt = '0;
                    case (r_state)
                        ST_SLOPE:  w_state_nxt = ST_CAP;
                        ST_CAP:    w_state_nxt = ST_SETTLE;
                        ST_SETTLE: begin
                            w_state_nxt  = ST_P1;
                            w_ff_clk_nxt = 1'b1;
                        end
                        ST_P1: begin
                            w_state_nxt  = ST_P2;
                            w_ff_clk_nxt = 1'b0;
                        end
                        ST_P2: begin
                            w_state_nxt  = ST_P3;
                            w_ff_din_nxt = 1'b1;
                        end
                        ST_P3: begin
                            w_state_nxt  = ST_P4;
                            w_ff_clk_nxt = 1'b1;
                        end
                        ST_P4:     w_state_nxt = ST_CHECK;
                        ST_P5: begin
                            w_state_nxt  = ST_P6;
                            w_ff_din_nxt = 1'b0;
                        end
                        ST_P6: begin
                            w_ff_clk_nxt = 1'b0;
                            if (r_capa < C_CAPA_LAST) begin
                                w_state_nxt = ST_CAP;
                                w_capa_nxt  = r_capa + 1'b1;
                            end else if (r_slope < C_SLOPE_LAST) begin
                                w_state_nxt = ST_SLOPE;
                                w_slope_nxt = r_slope + 1'b1;
                                w_capa_nxt  = '0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                        default:   w_state_nxt = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tick   <= '0;
            r_slope  <= '0;
            r_capa   <= '0;
            r_ff_clk <= 1'b0;
            r_ff_din <= 1'b0;
            r_ref_q  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
            r_index  <= '0;
            r_pass   <= 1'b0;
            r_fail   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_slope  <= w_slope_nxt;
            r_capa   <= w_capa_nxt;
            r_ff_clk <= w_ff_clk_nxt;
            r_ff_din <= w_ff_din_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_strobe <= w_enter_check;
            // Reference flop sees the same rising edge that the ff_clk register produces.
            if (!r_ff_clk && w_ff_clk_nxt) begin
                r_ref_q <= r_ff_din;
            end
            if (w_enter_check) begin
                r_valid <= 1'b1;
                r_index <= w_point;
                r_pass  <= w_match;
                if (!w_match && (r_fail != '1)) begin
                    r_fail <= r_fail + 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_start_acc) begin
                r_fail <= '0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign slope_idx   = r_slope;
    assign capa_idx    = r_capa;
    assign ff_clk      = r_ff_clk;
    assign ff_din      = r_ff_din;
    assign meas_strobe = r_strobe;
    assign rec_valid   = r_valid;
    assign rec_index   = r_index;
    assign rec_pass    = r_pass;
    assign fail_count  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_char_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_sweep_sequencer
// Brief    : Self-checking bench: timeline model of the sweep plus a flop-under-test
//            model, with directed and randomized backpressure / fault patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_sweep_sequencer;
    import char_pkg::*;

    localparam int T  = 4;
    localparam int NS = 7;
    localparam int NC = 7;
    localparam int NP = NS * NC;

    logic       clk = 1'b0;
    logic       rst, start, rec_ready, ff_dout;
    logic       busy, done, ff_clk, ff_din, meas_strobe, rec_valid, rec_pass;
    logic [2:0] slope_idx, capa_idx;
    logic [5:0] rec_index, fail_count;

    always #5 clk = ~clk;

    char_sweep_sequencer #(.NBSLOPES(NS), .NBCAPA(NC), .TICK_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .slope_idx(slope_idx), .capa_idx(capa_idx), .ff_clk(ff_clk), .ff_din(ff_din),
        .ff_dout(ff_dout), .meas_strobe(meas_strobe), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_index(rec_index), .rec_pass(rec_pass),
        .fail_count(fail_count)
    );

    // Flop under test: ideal capture, optionally forced low on faulty points.
    logic ideal_q   = 1'b0;
    bit   cur_fault = 1'b0;
    bit   faulty [NP];
    always @(posedge ff_clk) ideal_q <= ff_din;
    assign ff_dout = ideal_q & ~cur_fault;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a point is [SLOPE tick if first of row] + 6 ticks + check + 2 ticks.
    function automatic int pre_len(input int p);
        return (p % NC == 0) ? T : 0;
    endfunction
    function automatic int chk_off(input int p);
        return pre_len(p) + 6 * T;
    endfunction
    function automatic int pt_len(input int p);
        return pre_len(p) + 8 * T + 1;
    endfunction

    bit m_active = 0, m_done = 0, m_rec_pass = 0;
    int m_point = 0, m_off = 0, m_stall = 0, m_rec_index = 0, m_fail = 0;
    int m_edge = 0, m_records = 0;

    always @(posedge clk) begin : p_model
        m_done = 1'b0;
        if (rst === 1'b1) begin
            m_active = 0; m_fail = 0; m_rec_index = 0; m_rec_pass = 0;
        end else if (!m_active) begin
            m_edge++;
            if (start === 1'b1) begin
                m_active = 1; m_point = 0; m_off = 0; m_stall = 0;
                m_fail = 0; m_edge = 0; m_records = 0;
            end
        end else begin
            m_edge++;
            if (m_off == chk_off(m_point)) begin
                if (rec_ready === 1'b1) begin
                    m_records++;
`ifdef CHAR_ABORT_ON_MISMATCH_EN
                    if (!m_rec_pass) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_off++;
                    end
`else
                    m_off++;
`endif
                end else begin
                    m_stall++;
                end
            end else begin
                m_off++;
                if (m_off == chk_off(m_point)) begin
                    m_stall     = 0;
                    m_rec_index = m_point;
                    m_rec_pass  = !faulty[m_point];
                    if (!m_rec_pass && m_fail < 63) m_fail++;
                end else if (m_off == pt_len(m_point)) begin
                    if (m_point == NP - 1) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_point++; m_off = 0;
                    end
                end
            end
        end
    end

    bit check_en  = 0;
    int n_dut_rec = 0;
    int v5_cycles = 0;

    always @(negedge clk) begin : p_cmp
        bit e_clk, e_din, e_valid, e_strobe;
        int q, k;
        cur_fault = m_active && faulty[m_point];
        if (check_en) begin
            e_clk = 0; e_din = 0; e_valid = 0; e_strobe = 0;
            if (m_active) begin
                q = m_off - pre_len(m_point);
                if (q == 6 * T) begin
                    e_clk = 1; e_din = 1; e_valid = 1; e_strobe = (m_stall == 0);
                end else if (q > 6 * T) begin
                    k = (q - 6 * T - 1) / T;
                    e_clk = 1; e_din = (k == 0);
                end else if (q >= 0) begin
                    k = q / T;
                    e_clk = (k == 2) || (k == 5);
                    e_din = (k == 4) || (k == 5);
                end
                chk("slope_idx", slope_idx, m_point / NC);
                chk("capa_idx", capa_idx, m_point % NC);
            end
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("ff_clk", ff_clk, e_clk);
            chk("ff_din", ff_din, e_din);
            chk("meas_strobe", meas_strobe, e_strobe);
            chk("rec_valid", rec_valid, e_valid);
            chk("fail_count", fail_count, m_fail);
            if (e_valid) begin
                chk("rec_index", rec_index, m_rec_index);
                chk("rec_pass", rec_pass, m_rec_pass);
            end
            if (rec_valid === 1'b1 && rec_ready === 1'b1) begin
                chk("rec_order", rec_index, n_dut_rec);
                n_dut_rec++;
            end
            if (rec_valid === 1'b1 && rec_index == 6'd5) v5_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        n_dut_rec = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done; optional random backpressure, a 10-cycle stall at one
    // point, and a stray start pulse at a given cycle.
    task automatic wait_done(input string name, input bit rnd, input int stall_pt,
                             input int repulse_at, output int at);
        bit stalled = 0;
        at = -1;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (done === 1'b1) begin
                at = m_edge;
                break;
            end
            if (rnd) rec_ready = ($urandom_range(0, 3) != 0);
            if (i == repulse_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (!stalled && stall_pt >= 0 && m_active && m_point == stall_pt
                && m_off == chk_off(stall_pt)) begin
                rec_ready = 1'b0;
                repeat (10) tick();
                rec_ready = 1'b1;
                stalled = 1;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: done not seen within cycle budget", name);
        end
        rec_ready = 1'b1;
    endtask

    initial begin
        int  at;
        bit  saw_done;
        rst = 1'b1; start = 1'b0; rec_ready = 1'b1;
        for (int i = 0; i < NP; i++) faulty[i] = 0;
        tick();
        check_en = 1;
        tick(); tick();
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_slope", slope_idx, 0); chk("rst_capa", capa_idx, 0);
        chk("rst_ff_clk", ff_clk, 0);   chk("rst_ff_din", ff_din, 0);
        chk("rst_strobe", meas_strobe, 0); chk("rst_valid", rec_valid, 0);
        chk("rst_index", rec_index, 0); chk("rst_pass", rec_pass, 0);
        chk("rst_fail", fail_count, 0);
        rst = 1'b0;
        tick();

        // Ideal flop, no backpressure, stray start while busy.
        do_start();
        wait_done("ideal", 0, -1, 300, at);
        chk("ideal_done_cycle", at, 1645);
        chk("ideal_records", n_dut_rec, 49);
        chk("ideal_fail", fail_count, 0);
        tick();

        // Output stuck low on every point.
        for (int i = 0; i < NP; i++) faulty[i] = 1;
        do_start();
        wait_done("stuck", 0, -1, -1, at);
        tick();
`ifdef CHAR_ABORT_ON_MISMATCH_EN
        chk("abort_records", n_dut_rec, 1);
        chk("abort_fail", fail_count, 1);
        chk("abort_ff_clk", ff_clk, 0);
        chk("abort_ff_din", ff_din, 0);
`else
        chk("stuck_done_cycle", at, 1645);
        chk("stuck_records", n_dut_rec, 49);
        chk("stuck_fail", fail_count, 49);
`endif
        for (int i = 0; i < NP; i++) faulty[i] = 0;

        // Ten-cycle stall on point 5.
        v5_cycles = 0;
        do_start();
        wait_done("stall", 0, 5, -1, at);
        chk("stall_done_cycle", at, 1655);
        chk("stall_valid_cycles", v5_cycles, 11);
        tick();

        // Random faults and random backpressure.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) faulty[i] = ($urandom_range(0, 5) == 0);
            do_start();
            wait_done("random", 1, -1, -1, at);
            chk("random_records", n_dut_rec, m_records);
            tick();
        end
        for (int i = 0; i < NP; i++) faulty[i] = 0;

        // Reset in P3 of point 20, then a clean restart.
        do_start();
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (m_active && m_point == 20 && m_off >= pre_len(20) + 4 * T) break;
        end
        chk("pre_rst_point", m_point, 20);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);   chk("mid_rst_ff_clk", ff_clk, 0);
        chk("mid_rst_ff_din", ff_din, 0); chk("mid_rst_valid", rec_valid, 0);
        chk("mid_rst_slope", slope_idx, 0); chk("mid_rst_index", rec_index, 0);
        chk("mid_rst_fail", fail_count, 0);
        rst = 1'b0;
        saw_done = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        chk("no_done_after_rst", saw_done, 0);
        do_start();
        wait_done("restart", 0, -1, -1, at);
        chk("restart_done_cycle", at, 1645);
        chk("restart_records", n_dut_rec, 49);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
